// File: rtl/irq_stim_pkg.sv
// Shared types and constants for the interrupt stimulus generator.
package irq_stim_pkg;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_IDLE  = 2'b01;
    localparam logic [1:0] MODE_FREE  = 2'b10;
    localparam logic [1:0] MODE_LEVEL = 2'b11;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        CH_WAIT = 2'd0,
        CH_FIRE = 2'd1,
        CH_HOLD = 2'd2
    } chan_state_e;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/irq_stim_chan.sv
// One interrupt channel: random-gap wait, fixed-width pulse or level-until-ack hold.
module irq_stim_chan
    import irq_stim_pkg::*;
#(
    parameter int GAP_WIDTH   = 3,
    parameter int PULSE_WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 eligible,
    input  logic                 force_off,
    input  logic                 level_mode,
    input  logic                 irq_ack,
    input  logic [GAP_WIDTH-1:0] reload,
    output logic                 irq,
    output logic                 fire
);

    chan_state_e          state_q, state_d;
    logic [GAP_WIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]           pcnt_q, pcnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pcnt_d  = pcnt_q;
        fire    = 1'b0;
        if (force_off) begin
            state_d = CH_WAIT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                CH_WAIT: begin
                    if (eligible) begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - GAP_WIDTH'(1);
                        end else begin
                            state_d = level_mode ? CH_HOLD : CH_FIRE;
                            pcnt_d  = 4'(PULSE_WIDTH - 1);
                            fire    = 1'b1;
                        end
                    end
                end
                CH_FIRE: begin
                    // pcnt holds the remaining high edges after the current one
                    if (pcnt_q == 4'd0) begin
                        state_d = CH_WAIT;
                        cnt_d   = reload;
                    end else begin
                        pcnt_d = pcnt_q - 4'd1;
                    end
                end
                CH_HOLD: begin
                    if (irq_ack) begin
                        state_d = CH_WAIT;
                        cnt_d   = reload;
                    end
                end
                default: state_d = CH_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CH_WAIT;
            cnt_q   <= '0;
            pcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
        end
    end

    assign irq = (state_q != CH_WAIT);

endmodule

// File: rtl/irq_stim_gen.sv
// Interrupt stimulus generator with shared LFSR, halt-opcode detector and drain timer.
module irq_stim_gen
    import irq_stim_pkg::*;
#(
    parameter int          NUM_CH       = 4,
    parameter int          GAP_WIDTH    = 3,
    parameter int          PULSE_WIDTH  = 1,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          INSTR_WIDTH  = 32,
    parameter logic [9:0]  HALT_OPCODE  = 10'b0000000001,
    parameter int          DRAIN_CYCLES = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             mode,
    input  logic [NUM_CH-1:0]      ch_mask,
    input  logic                   ps_idle,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic [NUM_CH-1:0]      irq_ack,
    output logic [NUM_CH-1:0]      irq,
    output logic                   halt_seen,
    output logic                   test_done,
    output logic [15:0]            irq_count
);

    // An all-zero seed would lock the LFSR.
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    logic [15:0]       lfsr_q, lfsr_d;
    logic              halt_seen_q, halt_seen_d;
    logic              test_done_q, test_done_d;
    logic [7:0]        drain_q, drain_d;
    logic [15:0]       irq_count_q, irq_count_d;
    logic [NUM_CH-1:0] fire;
    logic [3:0]        fire_sum;
    logic [16:0]       count_sum;
    logic              elig_base;
    logic              unused_instr;

    assign unused_instr = ^instr[INSTR_WIDTH-11:0];

    // halt_seen is registered, so a fire eligible on the halt edge still happens
    assign elig_base = !halt_seen_q && (mode != MODE_OFF) && ((mode != MODE_IDLE) || ps_idle);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
        irq_stim_chan #(
            .GAP_WIDTH  (GAP_WIDTH),
            .PULSE_WIDTH(PULSE_WIDTH)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .eligible  (ch_mask[ch] && elig_base),
            .force_off (mode == MODE_OFF),
            .level_mode(mode == MODE_LEVEL),
            .irq_ack   (irq_ack[ch]),
            .reload    (lfsr_q[GAP_WIDTH*ch +: GAP_WIDTH]),
            .irq       (irq[ch]),
            .fire      (fire[ch])
        );
    end

    always_comb begin
        lfsr_d = (mode != MODE_OFF) ? lfsr_next(lfsr_q) : lfsr_q;

        fire_sum = 4'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            fire_sum = fire_sum + 4'(fire[i]);
        end
        count_sum   = {1'b0, irq_count_q} + {13'd0, fire_sum};
        irq_count_d = count_sum[16] ? 16'hFFFF : count_sum[15:0];

        halt_seen_d = halt_seen_q || (instr[INSTR_WIDTH-1 -: 10] == HALT_OPCODE);
        test_done_d = test_done_q;
        drain_d     = drain_q;
        if (halt_seen_q && !test_done_q) begin
            drain_d = drain_q + 8'd1;
            if (drain_q == 8'(DRAIN_CYCLES - 1)) begin
                test_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q      <= SEED;
            halt_seen_q <= 1'b0;
            test_done_q <= 1'b0;
            drain_q     <= 8'd0;
            irq_count_q <= 16'd0;
        end else begin
            lfsr_q      <= lfsr_d;
            halt_seen_q <= halt_seen_d;
            test_done_q <= test_done_d;
            drain_q     <= drain_d;
            irq_count_q <= irq_count_d;
        end
    end

    assign halt_seen = halt_seen_q;
    assign test_done = test_done_q;
    assign irq_count = irq_count_q;

endmodule

// File: doc/irq_stim_gen.md
# irq_stim_gen

Parametrised, synthesizable interrupt stimulus and end-of-test generator for core-level simulation and FPGA self-test of `core_top`.
- Drives `NUM_CH` independent interrupt lines, each fired after pseudo-random gaps drawn from a shared LFSR.
- Modes: idle-gated pulse, free-running pulse, and level-until-acknowledge.
- Watches the program-memory instruction bus for the halt opcode and raises a sticky `test_done` after a fixed drain period.

## Interface
- `NUM_CH`, 4: number of interrupt channels (1..8).
- `GAP_WIDTH`, 3: gap counter width. Requires `NUM_CH*GAP_WIDTH <= 16`.
- `PULSE_WIDTH`, 1: irq high time in cycles for pulse modes (1..15).
- `LFSR_SEED`, 16'hACE1: LFSR reset value. A seed of 0 is replaced by 16'h0001.
- `INSTR_WIDTH`, 32: width of the instruction bus.
- `HALT_OPCODE`, 10'b0000000001: value of `instr[INSTR_WIDTH-1 -: 10]` that marks halt.
- `DRAIN_CYCLES`, 5: cycles from `halt_seen` to `test_done` (1..255).

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low
- `mode`  in  2  00 off, 01 idle-gated pulse, 10 free-running pulse, 11 level-until-ack
- `ch_mask`  in  NUM_CH  1 = channel enabled
- `ps_idle`  in  1  sequencer idle flag
- `instr`  in  INSTR_WIDTH  fetched instruction (`pm_ps_op`)
- `irq_ack`  in  NUM_CH  per-channel acknowledge (used in mode 11 only)
- `irq`  out  NUM_CH  registered interrupt lines
- `halt_seen`  out  1  sticky halt-detected flag
- `test_done`  out  1  sticky end-of-test flag
- `irq_count`  out  16  total fires, saturating

## Operation
- **LFSR:** 16-bit Galois, taps x^16+x^14+x^13+x^11. Advances every cycle while `mode != 00`.
- **Channel FSM states:** WAIT, FIRE, HOLD.
  - Each channel has a gap counter `cnt` of `GAP_WIDTH` bits and a pulse counter of 4 bits.
- **Eligibility:** a channel is eligible when all of the following hold: `ch_mask` bit set, `halt_seen == 0`, `mode != 00`, and (`mode != 01` or `ps_idle`).
- **WAIT:**
  - If eligible and `cnt != 0`: decrement `cnt`.
  - If eligible and `cnt == 0`: go to FIRE if mode is 01/10, or HOLD if mode is 11. `irq` is set high on the same edge.
  - If not eligible: `cnt` is frozen.
- **FIRE:** `irq` stays high for exactly `PULSE_WIDTH` cycles, then the channel returns to WAIT with `irq` low.
- **HOLD:** `irq` stays high until `irq_ack` is sampled high, then the channel returns to WAIT with `irq` low.
- **Gap reload:** on every return to WAIT, `cnt` loads `lfsr[GAP_WIDTH*ch +: GAP_WIDTH]`, using the LFSR value at that edge.
- **Mode changes:**
  - Changing to mode 00 in any state forces WAIT, `irq` low, and `cnt` = 0 on the next edge.
  - A channel already in FIRE or HOLD keeps its current state when the mode changes between non-zero values.
- **Mask changes:** clearing a `ch_mask` bit while that channel is in FIRE or HOLD does not cut the pulse. It only blocks the next fire.
- **Halt detection:**
  - If `instr[INSTR_WIDTH-1 -: 10] == HALT_OPCODE`, `halt_seen` is set on the next edge and stays set until reset.
  - A drain counter then counts `DRAIN_CYCLES` cycles and sets `test_done`, also sticky.
  - After halt, no new fires occur. Pulses and holds already in progress complete normally.
- **irq_count:** adds the popcount of channels entering FIRE or HOLD each cycle and saturates at 16'hFFFF.

## Timing
- **Reset values:** `irq` = 0, `halt_seen` = 0, `test_done` = 0, `irq_count` = 0, every `cnt` = 0, all channels in WAIT, LFSR = seed.
- **First fire:** since `cnt` is 0 after reset, the first fire happens on the first edge where the channel is eligible.
- **Pulse length:** `irq` is high for exactly `PULSE_WIDTH` edges.
- **Minimum spacing:** at least 1 low cycle between pulses on the same channel, plus the gap value.
- **HOLD release:** `irq_ack` high at edge N drops `irq` after edge N. `irq_ack` asserted during WAIT or FIRE is ignored.
- **Halt timing:**
  - Halt opcode sampled at edge N gives `halt_seen` = 1 after N.
  - `test_done` = 1 after edge N + `DRAIN_CYCLES`.
  - A fire eligible at edge N still occurs, because `halt_seen` is registered.
- **Reset mid-operation:** asynchronous clear of all state within the same cycle, including drain and sticky flags.

## Structure
- Package `irq_stim_pkg` holds:
  - the mode encoding constants `MODE_OFF`, `MODE_IDLE`, `MODE_FREE`, `MODE_LEVEL`;
  - the channel state enum;
  - the LFSR tap constant.
- Sub-module `irq_stim_chan` contains one channel FSM with its gap and pulse counters. The top level instantiates it `NUM_CH` times via generate and holds the shared LFSR, halt detector, drain counter and `irq_count`.

## Test plan
- **Reset:** assert reset mid-pulse with mode 10 and mask 4'hF → all outputs 0 immediately. After release with `ps_idle` = 1, all four channels fire on the first edge.
- **Mode 01 gating:**
  - Mask 4'h1 with `ps_idle` = 0 for 100 cycles → `irq` stays 0 and `irq_count` stays 0.
  - Raising `ps_idle` → `irq[0]` goes high after the next edge for exactly 1 cycle.
- **Mode 11 hold:** mask 4'h2, `irq_ack` withheld 20 cycles → `irq[1]` stays high all 20 cycles. `irq_ack[1]` pulse → low the following cycle. `irq_count` = 1.
- **Pulse spacing:** mode 10, mask 4'hF, `PULSE_WIDTH` = 3, 1000 cycles → every pulse is 3 cycles long, and gaps match a reference LFSR model cycle-exactly.
- **Halt:** `instr` = 32'h0040_0000 held for 1 cycle → `halt_seen` rises the next cycle, `test_done` rises 5 cycles later, and no new `irq` rising edge appears afterwards.
- **Mode-off abort:** switching to mode 00 during HOLD → `irq` low after the next edge, and re-enabling fires immediately because `cnt` = 0.
